// File: rtl/fpu_result_collector.sv
// Output stage of the FP coprocessor: captures the result of the unit named by the op queue head
// in order, acknowledges it, and buffers it in a first-word-fall-through FIFO that the CPU drains.
module fpu_result_collector #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 8,
    parameter int NUM_UNITS = 3,
    parameter int TAG_W     = 3
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic [NUM_UNITS*DATA_W-1:0] unit_result,
    input  logic [NUM_UNITS-1:0]        unit_done,
    output logic [NUM_UNITS-1:0]        unit_serv,
    input  logic                        op_valid,
    input  logic [TAG_W-1:0]            op_tag,
    output logic                        op_pop,
    input  logic                        cpu_pop,
    output logic [DATA_W-1:0]           result,
    output logic                        result_valid,
    output logic                        full,
    output logic [$clog2(DEPTH):0]      count,
    input  logic                        err_clr,
    output logic                        bad_tag_err,
    output logic                        underflow_err
);

    localparam int PTR_W     = $clog2(DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int TAG_RANGE = 2 ** TAG_W;

    logic [DATA_W-1:0]    mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [TAG_RANGE-1:0] done_ext;
    logic [TAG_RANGE-1:0] serv_dec;
    logic [DATA_W-1:0]    res_ext [TAG_RANGE];
    logic                 tag_ok;
    logic                 pop_ok;
    logic                 accept;
    logic                 bad_tag;

    // Widen the per-unit vectors to the full tag range so any tag value indexes safely;
    // tags with no unit behind them read as "not done" with a zero result.
    generate
        for (genvar k = 0; k < TAG_RANGE; k++) begin : g_res
            if (k < NUM_UNITS) begin : g_unit
                assign res_ext[k] = unit_result[k*DATA_W +: DATA_W];
            end else begin : g_none
                assign res_ext[k] = '0;
            end
        end
    endgenerate

    assign done_ext = TAG_RANGE'(unit_done);
    assign serv_dec = TAG_RANGE'(1) << op_tag;
    assign tag_ok   = {{(32-TAG_W){1'b0}}, op_tag} < 32'(NUM_UNITS);

    assign full         = (count == CNT_W'(DEPTH));
    assign result_valid = (count != '0);
    assign result       = mem[rd_ptr];

    // op_pop doubles as the busy flag: the cycle after a capture the unit still shows done,
    // so blocking that cycle prevents capturing the same result twice.
    assign pop_ok  = cpu_pop && (count != '0);
    assign accept  = op_valid && tag_ok && done_ext[op_tag] && !op_pop && (!full || cpu_pop);
    assign bad_tag = op_valid && !tag_ok && !op_pop;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            unit_serv     <= '0;
            op_pop        <= 1'b0;
            bad_tag_err   <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= res_ext[op_tag];
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count     <= count + CNT_W'(accept) - CNT_W'(pop_ok);
            unit_serv <= accept ? NUM_UNITS'(serv_dec) : '0;
            op_pop    <= accept || bad_tag;

            // Clear has priority over a set in the same cycle.
            if (err_clr) begin
                bad_tag_err   <= 1'b0;
                underflow_err <= 1'b0;
            end else begin
                if (bad_tag) begin
                    bad_tag_err <= 1'b1;
                end
                if (cpu_pop && (count == '0)) begin
                    underflow_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fpu_result_collector.sv
// Directed bench for fpu_result_collector: in-order capture, busy guard, backpressure with
// pointer wrap, bad tags, underflow, simultaneous push/pop and asynchronous reset.
module tb_fpu_result_collector;

    localparam int DATA_W    = 32;
    localparam int DEPTH     = 8;
    localparam int NUM_UNITS = 3;
    localparam int TAG_W     = 3;

    logic                        clk;
    logic                        n_rst;
    logic [NUM_UNITS*DATA_W-1:0] unit_result;
    logic [NUM_UNITS-1:0]        unit_done;
    logic [NUM_UNITS-1:0]        unit_serv;
    logic                        op_valid;
    logic [TAG_W-1:0]            op_tag;
    logic                        op_pop;
    logic                        cpu_pop;
    logic [DATA_W-1:0]           result;
    logic                        result_valid;
    logic                        full;
    logic [$clog2(DEPTH):0]      count;
    logic                        err_clr;
    logic                        bad_tag_err;
    logic                        underflow_err;

    int compared = 0;
    int mismatched = 0;

    fpu_result_collector #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_UNITS(NUM_UNITS), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .n_rst(n_rst), .unit_result(unit_result), .unit_done(unit_done),
        .unit_serv(unit_serv), .op_valid(op_valid), .op_tag(op_tag), .op_pop(op_pop),
        .cpu_pop(cpu_pop), .result(result), .result_valid(result_valid), .full(full),
        .count(count), .err_clr(err_clr), .bad_tag_err(bad_tag_err),
        .underflow_err(underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int tag, input logic [31:0] value);
        unit_result[tag*DATA_W +: DATA_W] = value;
        unit_done = '0;
        unit_done[tag] = 1'b1;
        op_tag = TAG_W'(tag);
        op_valid = 1'b1;
    endtask

    task automatic withdraw();
        unit_done = '0;
        op_valid = 1'b0;
    endtask

    task automatic push(input int tag, input logic [31:0] value);
        offer(tag, value);
        step();
        withdraw();
        step();
    endtask

    logic [31:0] expected_q [$];
    int serv_pulses;
    int pop_pulses;

    initial begin
        n_rst = 1'b0;
        unit_result = '0;
        unit_done = '0;
        op_valid = 1'b0;
        op_tag = '0;
        cpu_pop = 1'b0;
        err_clr = 1'b0;
        step();
        step();

        check_output("reset_count", 32'(count), 32'd0);
        check_output("reset_valid", 32'(result_valid), 32'd0);
        check_output("reset_result", result, 32'd0);
        check_output("reset_full", 32'(full), 32'd0);
        check_output("reset_serv_pop", {28'd0, unit_serv, op_pop}, 32'd0);
        check_output("reset_errs", {30'd0, bad_tag_err, underflow_err}, 32'd0);
        n_rst = 1'b1;
        step();

        // Single capture from unit 1
        offer(1, 32'h3F80_0000);
        step();
        check_output("t1_op_pop", 32'(op_pop), 32'd1);
        check_output("t1_serv", 32'(unit_serv), 32'b010);
        check_output("t1_result", result, 32'h3F80_0000);
        check_output("t1_valid", 32'(result_valid), 32'd1);
        check_output("t1_count", 32'(count), 32'd1);
        withdraw();
        step();
        check_output("t1_pulse_end", {28'd0, unit_serv, op_pop}, 32'd0);
        cpu_pop = 1'b1;
        step();
        cpu_pop = 1'b0;
        check_output("t1_drained", 32'(count), 32'd0);

        // Unit 0 holds done for 4 cycles; the op queue empties once popped
        offer(0, 32'hAAAA_0000);
        serv_pulses = 0;
        pop_pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            serv_pulses += int'(unit_serv[0]);
            pop_pulses += int'(op_pop);
            if (op_pop) op_valid = 1'b0;
        end
        check_output("t2_serv_pulses", 32'(serv_pulses), 32'd1);
        check_output("t2_pop_pulses", 32'(pop_pulses), 32'd1);
        check_output("t2_count", 32'(count), 32'd1);
        check_output("t2_result", result, 32'hAAAA_0000);
        withdraw();
        cpu_pop = 1'b1;
        step();
        cpu_pop = 1'b0;

        // Fill from pointer 2 so the ninth write wraps
        for (int i = 0; i < DEPTH; i++) begin
            push(i % NUM_UNITS, 32'h1000 + 32'(i));
            expected_q.push_back(32'h1000 + 32'(i));
        end
        check_output("t3_count_full", 32'(count), 32'd8);
        check_output("t3_full", 32'(full), 32'd1);
        check_output("t3_head", result, 32'h1000);
        offer(2, 32'h9999_0009);
        step();
        step();
        check_output("t3_hold_serv_pop", {28'd0, unit_serv, op_pop}, 32'd0);
        check_output("t3_hold_count", 32'(count), 32'd8);
        cpu_pop = 1'b1;
        step();
        cpu_pop = 1'b0;
        withdraw();
        void'(expected_q.pop_front());
        expected_q.push_back(32'h9999_0009);
        check_output("t3_serv_on_pop", 32'(unit_serv), 32'b100);
        check_output("t3_op_pop_on_pop", 32'(op_pop), 32'd1);
        check_output("t3_count_stays", 32'(count), 32'd8);
        for (int j = 0; j < DEPTH; j++) begin
            check_output($sformatf("t3_order_%0d", j), result, expected_q[j]);
            cpu_pop = 1'b1;
            step();
        end
        cpu_pop = 1'b0;
        check_output("t3_empty", 32'(count), 32'd0);

        // Tag with no unit behind it
        offer(0, 32'hDEAD_BEEF);
        unit_done = 3'b111;
        op_tag = 3'd5;
        step();
        withdraw();
        check_output("t4_op_pop", 32'(op_pop), 32'd1);
        check_output("t4_no_serv", 32'(unit_serv), 32'd0);
        check_output("t4_count", 32'(count), 32'd0);
        check_output("t4_err_set", 32'(bad_tag_err), 32'd1);
        step();
        check_output("t4_err_sticky", 32'(bad_tag_err), 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check_output("t4_err_clr", 32'(bad_tag_err), 32'd0);

        // Underflow, then push and pop in the same cycle at count 1
        cpu_pop = 1'b1;
        step();
        cpu_pop = 1'b0;
        check_output("t5_underflow_count", 32'(count), 32'd0);
        check_output("t5_underflow_err", 32'(underflow_err), 32'd1);
        push(0, 32'h5555_0001);
        check_output("t5_one", 32'(count), 32'd1);
        offer(1, 32'h5555_0002);
        cpu_pop = 1'b1;
        step();
        withdraw();
        cpu_pop = 1'b0;
        check_output("t5_pushpop_count", 32'(count), 32'd1);
        check_output("t5_pushpop_head", result, 32'h5555_0002);
        check_output("t5_pushpop_serv", 32'(unit_serv), 32'b010);
        cpu_pop = 1'b1;
        step();
        err_clr = 1'b1;
        step();
        cpu_pop = 1'b0;
        err_clr = 1'b0;
        check_output("t5_clr_wins", 32'(underflow_err), 32'd0);

        // Asynchronous reset with 5 entries and an accept pending
        for (int i = 0; i < 5; i++) begin
            push(2, 32'h7000 + 32'(i));
        end
        check_output("t6_count5", 32'(count), 32'd5);
        offer(1, 32'h7777_7777);
        step();
        #2;
        n_rst = 1'b0;
        #1;
        check_output("t6_rst_count", 32'(count), 32'd0);
        check_output("t6_rst_valid", 32'(result_valid), 32'd0);
        check_output("t6_rst_serv_pop", {28'd0, unit_serv, op_pop}, 32'd0);
        withdraw();
        step();
        n_rst = 1'b1;
        step();
        check_output("t6_post_serv_pop", {28'd0, unit_serv, op_pop}, 32'd0);
        check_output("t6_post_count", 32'(count), 32'd0);
        check_output("t6_post_result", result, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
